// File: rtl/connect_router_buf_if.sv
// Ring-stop signal bundle for connect_router_buf plus the flit field layout it shares with the ring.
// Flit layout: [15] valid, [14:11] destination, [10:0] payload.
`ifndef CONTROL_W
`define CONTROL_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif
`ifndef DEST_F
`define DEST_F 14:11
`endif
`ifndef DEST_W
`define DEST_W 4
`endif

interface connect_router_buf_if #(
  parameter int DEPTH = 4
);
  logic [`CONTROL_W-1:0]         port_in;
  logic [`CONTROL_W-1:0]         inj;
  logic                          xfer_ready;
  logic [`CONTROL_W-1:0]         port_out;
  logic                          accept;
  logic [`CONTROL_W-1:0]         xfer_out;
  logic                          xfer_valid;
  logic [$clog2(DEPTH+1)-1:0]    occupancy;

  modport master (
    output port_in, inj, xfer_ready,
    input  port_out, accept, xfer_out, xfer_valid, occupancy
  );

  modport slave (
    input  port_in, inj, xfer_ready,
    output port_out, accept, xfer_out, xfer_valid, occupancy
  );
endinterface

// File: rtl/connect_router_buf.sv
// Two-stage ring stop that diverts flits addressed to DEST_LO..DEST_HI into a transfer FIFO for the other ring.
// Optional CONNECT_ROUTER_STATS_EN adds a saturating deflection counter output deflect_cnt.
module connect_router_buf #(
  parameter logic [3:0] ADDR    = 4'b0000,
  parameter int          DEST_LO = 4,
  parameter int          DEST_HI = 11,
  parameter int          DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  connect_router_buf_if.slave     bus
`ifdef CONNECT_ROUTER_STATS_EN
  ,
  output logic [15:0]             deflect_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [`DEST_W-1:0] LO = `DEST_W'(DEST_LO);
  localparam logic [`DEST_W-1:0] HI = `DEST_W'(DEST_HI);
  localparam logic [OW-1:0]      FULL_CNT = OW'(DEPTH);

  typedef logic [`CONTROL_W-1:0] flit_t;

  flit_t           s1;
  flit_t           port_out_q;
  flit_t           slot;
  flit_t           merged;
  flit_t           mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [OW-1:0]   occ;
  logic [`DEST_W-1:0] dest;
  logic            productive;
  logic            push;
  logic            pop;
  logic            xfer_valid_i;

  assign dest         = s1[`DEST_F];
  assign productive   = s1[`VALID_F] && (dest >= LO) && (dest <= HI);
  assign xfer_valid_i = (occ != '0);
  assign pop          = xfer_valid_i && bus.xfer_ready;
  // A pop frees the head slot on the same edge, so a full FIFO can still take a flit.
  assign push         = productive && ((occ != FULL_CNT) || pop);

  always_comb begin
    slot       = push ? '0 : s1;
    bus.accept = !slot[`VALID_F] && bus.inj[`VALID_F];
    merged     = bus.accept ? bus.inj : slot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      port_out_q <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
    end else begin
      s1         <= bus.port_in;
      port_out_q <= merged;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: pointers and occupancy clearing discards any stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1;
  end

  assign bus.port_out   = port_out_q;
  assign bus.xfer_valid = xfer_valid_i;
  assign bus.xfer_out   = xfer_valid_i ? mem[rd_ptr] : '0;
  assign bus.occupancy  = occ;

`ifdef CONNECT_ROUTER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      deflect_cnt <= '0;
    end else if (productive && !push && (deflect_cnt != '1)) begin
      deflect_cnt <= deflect_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_connect_router_buf.sv
// Directed self-checking bench for connect_router_buf (DEPTH=4, DEST 4..11).
module tb_connect_router_buf;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  connect_router_buf_if #(.DEPTH(4)) bus ();

`ifdef CONNECT_ROUTER_STATS_EN
  logic [15:0] deflect_cnt;
`endif

  connect_router_buf #(
    .ADDR(4'b0000), .DEST_LO(4), .DEST_HI(11), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CONNECT_ROUTER_STATS_EN
    ,
    .deflect_cnt(deflect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(input logic [3:0] dest, input logic [10:0] data);
    return {1'b1, dest, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [15:0] fa, fb, fi, fp, fj, fq, fk, fr, fs, ft, fu, fd;
  logic [15:0] fc [5];
  logic [15:0] drain [4];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.port_in = '0;
    bus.inj = '0;
    bus.xfer_ready = 1'b0;
    fa = mk(4'd2, 11'h011);
    fb = mk(4'd5, 11'h022);
    fi = mk(4'd12, 11'h0A1);
    fp = mk(4'd2, 11'h0B2);
    fj = mk(4'd13, 11'h0C3);
    fq = mk(4'd4, 11'h0D4);
    fk = mk(4'd14, 11'h0E5);
    fr = mk(4'd11, 11'h0F6);
    fs = mk(4'd12, 11'h107);
    ft = mk(4'd6, 11'h118);
    fu = mk(4'd8, 11'h129);
    fd = mk(4'd9, 11'h13A);
    for (int i = 0; i < 5; i++) fc[i] = mk(4'd7, 11'(12'h200 + i));

    step();
    step();
    rst = 1'b0;
    chk("rst_port_out", 32'(bus.port_out), 32'h0);
    chk("rst_xfer_valid", 32'(bus.xfer_valid), 32'h0);
    chk("rst_xfer_out", 32'(bus.xfer_out), 32'h0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'h0);
    chk("rst_accept_idle", 32'(bus.accept), 32'h0);

    // pass-through, dest outside capture range
    bus.port_in = fa;
    step();
    bus.port_in = '0;
    step();
    chk("pass_port_out", 32'(bus.port_out), 32'(fa));
    chk("pass_xfer_valid", 32'(bus.xfer_valid), 32'h0);
    step();
    chk("pass_port_out_clear", 32'(bus.port_out), 32'h0);

    // capture into FIFO
    bus.port_in = fb;
    step();
    bus.port_in = '0;
    step();
    chk("cap_port_out", 32'(bus.port_out), 32'h0);
    chk("cap_xfer_valid", 32'(bus.xfer_valid), 32'h1);
    chk("cap_occupancy", 32'(bus.occupancy), 32'h1);
    chk("cap_xfer_out", 32'(bus.xfer_out), 32'(fb));
    bus.xfer_ready = 1'b1;
    step();
    bus.xfer_ready = 1'b0;
    chk("pop_occupancy", 32'(bus.occupancy), 32'h0);
    chk("pop_xfer_valid", 32'(bus.xfer_valid), 32'h0);
    chk("pop_xfer_out", 32'(bus.xfer_out), 32'h0);

    // fill to DEPTH, fifth flit deflected
    for (int i = 0; i < 5; i++) begin
      bus.port_in = fc[i];
      step();
    end
    bus.port_in = '0;
    step();
    chk("full_occupancy", 32'(bus.occupancy), 32'h4);
    chk("full_deflect_out", 32'(bus.port_out), 32'(fc[4]));
    chk("full_head", 32'(bus.xfer_out), 32'(fc[0]));
`ifdef CONNECT_ROUTER_STATS_EN
    chk("full_deflect_cnt", 32'(deflect_cnt), 32'h1);
`endif
    step();
    chk("full_out_clear", 32'(bus.port_out), 32'h0);

    // full with simultaneous pop
    bus.port_in = fd;
    step();
    bus.port_in = '0;
    bus.xfer_ready = 1'b1;
    step();
    chk("fullpop_occupancy", 32'(bus.occupancy), 32'h4);
    chk("fullpop_port_out", 32'(bus.port_out), 32'h0);
`ifdef CONNECT_ROUTER_STATS_EN
    chk("fullpop_deflect_cnt", 32'(deflect_cnt), 32'h1);
`endif
    drain[0] = fc[1];
    drain[1] = fc[2];
    drain[2] = fc[3];
    drain[3] = fd;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_%0d", i), 32'(bus.xfer_out), 32'(drain[i]));
      step();
    end
    bus.xfer_ready = 1'b0;
    chk("drain_occupancy", 32'(bus.occupancy), 32'h0);
    chk("drain_xfer_valid", 32'(bus.xfer_valid), 32'h0);

    // injection into empty slot
    bus.inj = fi;
    #1;
    chk("inj_accept", 32'(bus.accept), 32'h1);
    step();
    bus.inj = '0;
    chk("inj_port_out", 32'(bus.port_out), 32'(fi));

    // injection blocked by through-traffic
    bus.port_in = fp;
    step();
    bus.port_in = '0;
    bus.inj = fj;
    #1;
    chk("inj_blocked_accept", 32'(bus.accept), 32'h0);
    step();
    bus.inj = '0;
    chk("inj_blocked_port_out", 32'(bus.port_out), 32'(fp));

    // captured flit at DEST_LO frees its slot for injection
    bus.port_in = fq;
    step();
    bus.port_in = '0;
    bus.inj = fk;
    #1;
    chk("inj_freed_accept", 32'(bus.accept), 32'h1);
    step();
    bus.inj = '0;
    chk("inj_freed_port_out", 32'(bus.port_out), 32'(fk));
    chk("lo_occupancy", 32'(bus.occupancy), 32'h1);
    chk("lo_xfer_out", 32'(bus.xfer_out), 32'(fq));

    // DEST_HI captured, DEST_HI+1 passes through
    bus.port_in = fr;
    step();
    bus.port_in = fs;
    step();
    bus.port_in = '0;
    step();
    chk("hi1_port_out", 32'(bus.port_out), 32'(fs));
    chk("hi_occupancy", 32'(bus.occupancy), 32'h2);
    chk("hi_head_kept", 32'(bus.xfer_out), 32'(fq));

    // reset mid-run with three buffered and one in flight
    bus.port_in = ft;
    step();
    bus.port_in = '0;
    step();
    chk("pre_rst_occupancy", 32'(bus.occupancy), 32'h3);
    bus.port_in = fu;
    step();
    bus.port_in = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_occupancy", 32'(bus.occupancy), 32'h0);
    chk("midrst_xfer_valid", 32'(bus.xfer_valid), 32'h0);
    chk("midrst_port_out", 32'(bus.port_out), 32'h0);
    chk("midrst_xfer_out", 32'(bus.xfer_out), 32'h0);
    bus.inj = fk;
    #1;
    chk("midrst_accept", 32'(bus.accept), 32'h1);
    bus.inj = '0;
    step();
    chk("postrst_port_out", 32'(bus.port_out), 32'h0);
    chk("postrst_occupancy", 32'(bus.occupancy), 32'h0);
`ifdef CONNECT_ROUTER_STATS_EN
    chk("postrst_deflect_cnt", 32'(deflect_cnt), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
